// File: rtl/simd_pkg.sv
// Shared types and default sizing for the SIMD operand/result read path.
package simd_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_N     = 16;

  typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_EMIT = 1'b1
  } rd_state_t;

endpackage

// File: rtl/lane_mask_next.sv
// Combinational set-bit search over a lane mask.
// With first=1 it returns the lowest set bit; otherwise the lowest set bit
// strictly above cur_idx (never wraps). is_last reports that no set bit
// exists above the returned index.
module lane_mask_next
  import simd_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic [LANES-1:0]         mask,
  input  logic [$clog2(LANES)-1:0] cur_idx,
  input  logic                     first,
  output logic [$clog2(LANES)-1:0] next_idx,
  output logic                     found,
  output logic                     is_last
);

  localparam int IW = $clog2(LANES);

  // Scan lanes in ascending order; first hit is the answer, any later hit clears is_last.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    is_last  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && (first || (i > int'(cur_idx)))) begin
        if (!found) begin
          next_idx = IW'(i);
          found    = 1'b1;
        end else begin
          is_last  = 1'b0;
        end
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/vector_lane_reader.sv
// Captures a LANES x N vector plus lane mask and replays the selected lanes,
// lowest index first, one per cycle on a valid/ready stream.
module vector_lane_reader
  import simd_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int N     = DEF_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [LANES*N-1:0]       load_data,
  input  logic [LANES-1:0]         load_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_last,
  output logic                     done,
  output logic                     busy
);

  localparam int IW = $clog2(LANES);

  rd_state_t          state_r;
  rd_state_t          state_next_s;
  logic [LANES*N-1:0] data_r;
  logic [LANES-1:0]   mask_r;
  logic [IW-1:0]      lane_r;
  logic               out_valid_r;
  logic [N-1:0]       out_data_r;
  logic               out_last_r;
  logic               done_r;

  logic               load_fire_s;
  logic [IW-1:0]      first_idx_s;
  logic               first_found_s;
  logic               first_last_s;
  logic [IW-1:0]      next_idx_s;
  logic               next_found_s;
  logic               next_last_s;

  function automatic logic [N-1:0] lane_of(input logic [LANES*N-1:0] vec,
                                           input logic [IW-1:0]      idx);
    return vec[int'(idx)*N +: N];
  endfunction

  assign load_ready  = (state_r == RD_IDLE) && reset;
  assign busy        = (state_r == RD_EMIT);
  assign load_fire_s = load_valid && load_ready;

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_lane    = lane_r;
  assign out_last    = out_last_r;
  assign done        = done_r;

  // Lowest selected lane of the incoming vector.
  lane_mask_next #(.LANES(LANES)) u_first (
    .mask     (load_mask),
    .cur_idx  ('0),
    .first    (1'b1),
    .next_idx (first_idx_s),
    .found    (first_found_s),
    .is_last  (first_last_s)
  );

  // Next selected lane above the one currently presented.
  lane_mask_next #(.LANES(LANES)) u_next (
    .mask     (mask_r),
    .cur_idx  (lane_r),
    .first    (1'b0),
    .next_idx (next_idx_s),
    .found    (next_found_s),
    .is_last  (next_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: enter EMIT on a non-empty load, leave after the last beat is taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (load_fire_s && first_found_s) begin
          state_next_s = RD_EMIT;
        end else begin
          state_next_s = RD_IDLE;
        end
      end
      RD_EMIT: begin
        if (out_ready && out_last_r) begin
          state_next_s = RD_IDLE;
        end else begin
          state_next_s = RD_EMIT;
        end
      end
      default: state_next_s = RD_IDLE;
    endcase
  end

  // Capture registers, presented beat and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r      <= '0;
      mask_r      <= '0;
      lane_r      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        RD_IDLE: begin
          if (load_fire_s) begin
            data_r <= load_data;
            mask_r <= load_mask;
            if (first_found_s) begin
              out_valid_r <= 1'b1;
              lane_r      <= first_idx_s;
              out_data_r  <= lane_of(load_data, first_idx_s);
              out_last_r  <= first_last_s;
            end else begin
              done_r      <= 1'b1;
            end
          end
        end
        RD_EMIT: begin
          if (out_ready) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else if (next_found_s) begin
              lane_r      <= next_idx_s;
              out_data_r  <= lane_of(data_r, next_idx_s);
              out_last_r  <= next_last_s;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
